// File: rtl/com_fifo_pkg.sv
// Shared helpers for the com_* FIFO controllers.
`ifndef COM_SYS_W
`define COM_SYS_W 8
`endif

package com_fifo_pkg;

    // Advance a circular pointer; wraps at depth-1 so depth need not be a power of 2.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/com_tpram1ck_shell.sv
// Single-clock two-port RAM shell: one write port with lane strobes,
// one read port with a registered (1-cycle latency) output.
module com_tpram1ck_shell #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int STRB_W   = 1,
    parameter int MEM_USER = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [`COM_SYS_W-1:0] sys_cfg,
    input  logic [STRB_W-1:0]     wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data
);
    localparam int LANE_W = DATA_W / STRB_W;
    localparam logic [31:0] MEM_USER_V = 32'(MEM_USER);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              unused_cfg;

    // The behavioural shell has no use for the configuration inputs.
    assign unused_cfg = ^{sys_cfg, MEM_USER_V};

    // Lane-strobed write, registered read.
    always_ff @(posedge clk) begin
        for (int l = 0; l < STRB_W; l++) begin
            if (wr_en[l]) begin
                mem[wr_addr][l*LANE_W +: LANE_W] <= wr_data[l*LANE_W +: LANE_W];
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/com_tpram_fifo_ctrl.sv
// FWFT FIFO controller around one com_tpram1ck_shell. The RAM read latency
// is hidden by a single output stage: vld_p1 marks a word sitting on the RAM
// output, vld_p2/oreg_p2 hold a word that was not taken when it arrived.
module com_tpram_fifo_ctrl
    import com_fifo_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int MEM_USER = 0,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [`COM_SYS_W-1:0] sys_cfg,
    input  logic                  clr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [CNT_W-1:0]  ram_cnt;
    logic [CNT_W-1:0]  ram_cnt_nxt;
    logic              s_rdy_q;
    logic              full_q;
    logic              vld_p1;
    logic              vld_p2;
    logic [DATA_W-1:0] oreg_p2;
    logic [DATA_W-1:0] rd_data;
    logic              stage_v;
    logic              push;
    logic              pop;
    logic              rd_en;

    // Handshakes, read issue and output-stage decode.
    always_comb begin
        stage_v     = vld_p1 | vld_p2;
        s_ready     = s_rdy_q & ~clr;
        m_valid     = stage_v & ~clr;
        push        = s_valid & s_ready;
        pop         = m_valid & m_ready;
        // pop implies exactly one of vld_p1/vld_p2 is set, so the stage frees up
        rd_en       = ~clr & (ram_cnt != '0) & (~stage_v | pop);
        ram_cnt_nxt = ram_cnt + CNT_W'(push) - CNT_W'(rd_en);
        m_data      = vld_p1 ? rd_data : oreg_p2;
        count       = ram_cnt + CNT_W'(stage_v);
        empty       = (count == '0);
        full        = full_q;
    end

    // Pointers, RAM occupancy and the output stage; clr flushes to the reset state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            s_rdy_q <= 1'b1;
            full_q  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            oreg_p2 <= '0;
        end else if (clr) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            s_rdy_q <= 1'b1;
            full_q  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            oreg_p2 <= '0;
        end else begin
            if (push) begin
                wptr <= ADDR_W'(ptr_inc(32'(wptr), DEPTH));
            end
            if (rd_en) begin
                rptr <= ADDR_W'(ptr_inc(32'(rptr), DEPTH));
            end
            ram_cnt <= ram_cnt_nxt;
            s_rdy_q <= (ram_cnt_nxt < DEPTH_C);
            full_q  <= (ram_cnt_nxt == DEPTH_C);
            // --- stage p1 -> p2: capture the RAM word if it was not taken ---
            vld_p1  <= rd_en;
            if (vld_p1 && !pop) begin
                oreg_p2 <= rd_data;
                vld_p2  <= 1'b1;
            end else if (vld_p2 && pop) begin
                vld_p2  <= 1'b0;
            end
        end
    end

    com_tpram1ck_shell #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .STRB_W   (1),
        .MEM_USER (MEM_USER)
    ) u_ram (
        .clk     (clk),
        .sys_cfg (sys_cfg),
        .wr_en   (push),
        .wr_addr (wptr),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (rptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_com_tpram_fifo_ctrl.sv
// Bench for com_tpram_fifo_ctrl: a DEPTH=64 and a DEPTH=48 instance share
// stimulus, only the selected one receives valid/ready. A queue-based model
// tracks contents and when each head word may become visible.
module tb_com_tpram_fifo_ctrl;

    typedef struct {
        logic [31:0] d;
        int          pc;
    } ent_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  clr = 1'b0;
    logic                  s_valid = 1'b0;
    logic [31:0]           s_data = '0;
    logic                  m_ready = 1'b0;
    logic [`COM_SYS_W-1:0] sys_cfg = '0;
    logic                  sel = 1'b0;

    logic        sv0, sv1, mr0, mr1;
    logic        sr0, sr1, mv0, mv1, full0, full1, empty0, empty1;
    logic [31:0] md0, md1;
    logic [6:0]  cnt0;
    logic [5:0]  cnt1;

    logic        o_sr, o_mv, o_full, o_empty;
    logic [31:0] o_md;
    logic [6:0]  o_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   head_min = 0;
    ent_t q[$];
    logic last_push, last_pop;

    always #5 clk = ~clk;

    assign sv0 = s_valid & ~sel;
    assign sv1 = s_valid & sel;
    assign mr0 = m_ready & ~sel;
    assign mr1 = m_ready & sel;

    com_tpram_fifo_ctrl #(.DATA_W(32), .DEPTH(64), .MEM_USER(0)) u_dut0 (
        .clk(clk), .rst(rst), .sys_cfg(sys_cfg), .clr(clr),
        .s_valid(sv0), .s_ready(sr0), .s_data(s_data),
        .m_valid(mv0), .m_ready(mr0), .m_data(md0),
        .count(cnt0), .full(full0), .empty(empty0)
    );

    com_tpram_fifo_ctrl #(.DATA_W(32), .DEPTH(48), .MEM_USER(0)) u_dut1 (
        .clk(clk), .rst(rst), .sys_cfg(sys_cfg), .clr(clr),
        .s_valid(sv1), .s_ready(sr1), .s_data(s_data),
        .m_valid(mv1), .m_ready(mr1), .m_data(md1),
        .count(cnt1), .full(full1), .empty(empty1)
    );

    always_comb begin
        if (sel) begin
            o_sr = sr1; o_mv = mv1; o_md = md1; o_cnt = {1'b0, cnt1}; o_full = full1; o_empty = empty1;
        end else begin
            o_sr = sr0; o_mv = mv0; o_md = md0; o_cnt = cnt0; o_full = full0; o_empty = empty0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance.
    task automatic step(input logic sv, input logic [31:0] d, input logic mr, input logic c);
        int   depth;
        logic mv_raw, e_mv, e_full, e_sr;
        depth   = sel ? 48 : 64;
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        clr     = c;
        #1;
        mv_raw = (q.size() > 0) && (cyc >= q[0].pc + 2) && (cyc >= head_min);
        e_mv   = mv_raw && !c;
        e_full = ((q.size() - int'(mv_raw)) == depth);
        e_sr   = !e_full && !c;
        chk("m_valid", 32'(o_mv), 32'(e_mv));
        chk("s_ready", 32'(o_sr), 32'(e_sr));
        chk("count", 32'(o_cnt), 32'(q.size()));
        chk("full", 32'(o_full), 32'(e_full));
        chk("empty", 32'(o_empty), 32'(q.size() == 0));
        if (e_mv) chk("m_data", o_md, q[0].d);
        last_push = sv && e_sr;
        last_pop  = e_mv && mr;
        @(posedge clk);
        if (c) begin
            q.delete();
            head_min = 0;
        end else begin
            if (last_pop) begin
                void'(q.pop_front());
                head_min = cyc + 1;
            end
            if (last_push) q.push_back('{d, cyc});
        end
        cyc++;
        #1;
    endtask

    // Reset pulse that lands mid-cycle; outputs must drop at once.
    task automatic do_rst();
        s_valid = 1'b0;
        m_ready = 1'b0;
        clr     = 1'b0;
        rst     = 1'b1;
        #1;
        chk("rst_s_ready", 32'(o_sr), 32'd1);
        chk("rst_m_valid", 32'(o_mv), 32'd0);
        chk("rst_m_data", o_md, 32'd0);
        chk("rst_count", 32'(o_cnt), 32'd0);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        head_min = 0;
        cyc++;
    endtask

    // Fill with m_ready low, then drain; checks capacity and gap-free drain.
    task automatic fill_drain(input int cap);
        int acc, pops, first_pop, last_pop_cyc;
        acc = 0;
        for (int i = 0; i < cap + 5; i++) begin
            step(1'b1, 32'(acc), 1'b0, 1'b0);
            if (last_push) acc++;
        end
        chk("fill_accepted", 32'(acc), 32'(cap));
        chk("fill_count", 32'(o_cnt), 32'(cap));
        chk("fill_full", 32'(o_full), 32'd1);
        chk("fill_s_ready", 32'(o_sr), 32'd0);
        pops = 0;
        first_pop = -1;
        last_pop_cyc = -1;
        for (int i = 0; i < cap + 5; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
            if (last_pop) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop_cyc = cyc;
                pops++;
            end
        end
        chk("drain_pops", 32'(pops), 32'(cap));
        chk("drain_no_gaps", 32'(last_pop_cyc - first_pop), 32'(cap - 1));
    endtask

    initial begin
        int pops;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_rst();
        cyc = 0;

        // Single word: visible two cycles after the push, gone after the pop.
        step(1'b1, 32'hA5, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t1_m_valid", 32'(o_mv), 32'd1);
        chk("t1_m_data", o_md, 32'hA5);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t1_empty", 32'(o_empty), 32'd1);

        // Capacity DEPTH+1 on the 64-entry instance.
        fill_drain(65);

        // Streaming one push and one pop per cycle.
        pops = 0;
        for (int i = 0; i < 500; i++) begin
            step(1'b1, 32'(i), 1'b1, 1'b0);
            if (last_pop) pops++;
        end
        chk("stream_pops", 32'(pops), 32'd498);
        repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Random traffic with roughly 30% backpressure.
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 99) >= 30), 1'b0);
        end
        repeat (70) step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("rand_drained", 32'(o_empty), 32'd1);

        // Flush with 20 words stored and a RAM read in flight.
        for (int i = 0; i < 21; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("clr_pre_count", 32'(o_cnt), 32'd20);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        clr = 1'b0;
        #1;
        chk("clr_count", 32'(o_cnt), 32'd0);
        chk("clr_m_valid", 32'(o_mv), 32'd0);
        chk("clr_s_ready", 32'(o_sr), 32'd1);
        step(1'b1, 32'h1234, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("clr_first_word", o_md, 32'h1234);
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Non-power-of-2 depth: wrap 47 -> 0, capacity 49, reset mid-stream.
        sel = 1'b1;
        do_rst();
        fill_drain(49);
        for (int i = 0; i < 250; i++) begin
            if (i == 120) do_rst();
            step(1'($urandom_range(0, 99) < 75), 32'(1000 + i), 1'($urandom_range(0, 99) < 70), 1'b0);
        end
        repeat (60) step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("d48_drained", 32'(o_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
